// File: rtl/bit_counter_pkg.sv
// Shared types and sizing helpers for the bit_counter population-count engine.
package bit_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Bits needed to hold any value 0..data_w, i.e. clog2(data_w+1).
  function automatic int calc_sum_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bit_counter_datapath.sv
// Shift register, bit counter and accumulator for bit_counter.
// Optional feature macro: BIT_COUNTER_EARLY_EXIT_EN (stop once no 1-bits remain).
module bit_counter_datapath
  import bit_counter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SUM_W  = calc_sum_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  sum,
  output logic              last
);

  localparam int CNT_W = calc_sum_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shreg_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [SUM_W-1:0]  sum_r;
  logic              last_s;

  // Clear beats load beats step, mirroring the start-over-load priority in the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {SUM_W{1'b0}};
    end else if (clear) begin
      shreg_r <= shreg_r;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {SUM_W{1'b0}};
    end else if (load) begin
      shreg_r <= data;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= sum_r;
    end else if (step) begin
      shreg_r <= {1'b0, shreg_r[DATA_W-1:1]};
      cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      sum_r   <= sum_r + {{(SUM_W-1){1'b0}}, shreg_r[0]};
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
      sum_r   <= sum_r;
    end
  end

  // The step in progress is the final one: either all bits walked, or (early exit) nothing left above bit 0.
  always_comb begin
`ifdef BIT_COUNTER_EARLY_EXIT_EN
    last_s = (cnt_r == LAST_IDX) || (shreg_r[DATA_W-1:1] == {(DATA_W-1){1'b0}});
`else
    last_s = (cnt_r == LAST_IDX);
`endif
  end

  assign sum  = sum_r;
  assign last = last_s;

endmodule

// File: rtl/bit_counter.sv
// Sequential population counter: start arms, load captures, one bit counted per clock.
// Optional feature macro: BIT_COUNTER_EARLY_EXIT_EN (handled in bit_counter_datapath).
module bit_counter
  import bit_counter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SUM_W  = calc_sum_w(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_done
);

  state_t state_r;
  logic   done_r;
  logic   clear_s;
  logic   load_s;
  logic   step_s;
  logic   last_s;

  // Datapath strobes; start wins over load and over counting in every state.
  always_comb begin
    clear_s = i_start;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      ST_ARMED: load_s = i_load & ~i_start;
      ST_COUNT: step_s = ~i_start;
      default: begin
        load_s = 1'b0;
        step_s = 1'b0;
      end
    endcase
  end

  // Control FSM with registered done flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            state_r <= ST_ARMED;
            done_r  <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (i_start) begin
            state_r <= ST_ARMED;
          end else if (i_load) begin
            state_r <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (i_start) begin
            state_r <= ST_ARMED;
            done_r  <= 1'b0;
          end else if (last_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_start) begin
            state_r <= ST_ARMED;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  bit_counter_datapath #(
    .DATA_W(DATA_W),
    .SUM_W (SUM_W)
  ) u_datapath (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clear(clear_s),
    .load (load_s),
    .step (step_s),
    .data (i_data),
    .sum  (o_sum),
    .last (last_s)
  );

  assign o_done = done_r;

endmodule

// File: tb/tb_bit_counter.sv
// Self-checking bench for bit_counter: directed steps plus random words against a popcount model.
module tb_bit_counter;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 4;
`ifdef BIT_COUNTER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              load;
  logic [DATA_W-1:0] data;
  logic [SUM_W-1:0]  sum;
  logic              done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bit_counter #(.DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_load (load),
    .i_data (data),
    .o_sum  (sum),
    .o_done (done)
  );

  // Number of set bits among the lowest nbits of v.
  function automatic int popcnt(input logic [DATA_W-1:0] v, input int nbits);
    int c = 0;
    for (int i = 0; i < nbits; i++) if (v[i] === 1'b1) c++;
    return c;
  endfunction

  // Edges from load to done: DATA_W, or position of highest 1-bit (min 1) with early exit.
  function automatic int latency(input logic [DATA_W-1:0] v);
    int hi = 1;
    for (int i = 0; i < DATA_W; i++) if (v[i] === 1'b1) hi = i + 1;
    return EARLY ? hi : DATA_W;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    check("reset_sum", {28'd0, sum}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  // Load w from ARMED and follow the count edge by edge against the model.
  task automatic count_word(input logic [DATA_W-1:0] w, input string tag);
    int lat;
    lat  = latency(w);
    load = 1'b1;
    data = w;
    tick();
    load = 1'b0;
    data = DATA_W'($urandom);
    check($sformatf("%s_load_done", tag), {31'd0, done}, 32'd0);
    check($sformatf("%s_load_sum", tag), {28'd0, sum}, 32'd0);
    for (int k = 1; k <= lat; k++) begin
      tick();
      check($sformatf("%s_sum_e%0d", tag, k), {28'd0, sum}, 32'(popcnt(w, k)));
      check($sformatf("%s_done_e%0d", tag, k), {31'd0, done}, (k == lat) ? 32'd1 : 32'd0);
    end
    tick();
    tick();
    check($sformatf("%s_hold_sum", tag), {28'd0, sum}, 32'(popcnt(w, DATA_W)));
    check($sformatf("%s_hold_done", tag), {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    load  = 1'b0;
    data  = '0;
    #12;
    check("por_sum", {28'd0, sum}, 32'd0);
    check("por_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 0xFF after a 3-cycle armed wait
    pulse_start();
    repeat (3) tick();
    count_word(8'hFF, "ff");

    // restart from DONE clears on the start edge
    pulse_start();
    check("restart_sum", {28'd0, sum}, 32'd0);
    check("restart_done", {31'd0, done}, 32'd0);
    count_word(8'h38, "h38");

    apply_reset();
    pulse_start();
    count_word(8'h03, "h03");
    apply_reset();
    pulse_start();
    count_word(8'h0F, "h0f");

    // load in IDLE is ignored
    apply_reset();
    load = 1'b1;
    data = 8'hFF;
    tick();
    load = 1'b0;
    repeat (DATA_W + 2) tick();
    check("idle_load_done", {31'd0, done}, 32'd0);
    check("idle_load_sum", {28'd0, sum}, 32'd0);

    // start and load on the same edge: armed, load dropped
    start = 1'b1;
    load  = 1'b1;
    data  = 8'hFF;
    tick();
    start = 1'b0;
    load  = 1'b0;
    repeat (DATA_W + 2) tick();
    check("startload_done", {31'd0, done}, 32'd0);
    check("startload_sum", {28'd0, sum}, 32'd0);
    count_word(8'hA5, "after_startload");

    // asynchronous reset mid-count
    pulse_start();
    load = 1'b1;
    data = 8'hFF;
    tick();
    load = 1'b0;
    repeat (4) tick();
    check("midcount_sum", {28'd0, sum}, 32'd4);
    apply_reset();
    check("post_reset_done", {31'd0, done}, 32'd0);

    // start during COUNT aborts back to ARMED
    pulse_start();
    load = 1'b1;
    data = 8'hFF;
    tick();
    load = 1'b0;
    repeat (3) tick();
    pulse_start();
    check("abort_sum", {28'd0, sum}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (DATA_W + 2) tick();
    check("abort_idle_sum", {28'd0, sum}, 32'd0);
    check("abort_idle_done", {31'd0, done}, 32'd0);
    count_word(8'h5A, "after_abort");

    // held start with load stays armed, then a clean load counts
    start = 1'b1;
    load  = 1'b1;
    data  = 8'hFF;
    repeat (3) tick();
    start = 1'b0;
    load  = 1'b0;
    check("held_start_sum", {28'd0, sum}, 32'd0);
    check("held_start_done", {31'd0, done}, 32'd0);
    count_word(8'h81, "after_held");

    // early-exit boundary words (full latency without the feature)
    pulse_start();
    count_word(8'h01, "h01");
    pulse_start();
    count_word(8'h00, "h00");

    // random words with random armed gaps
    for (int n = 0; n < 16; n++) begin
      pulse_start();
      repeat ($urandom_range(0, 3)) tick();
      count_word(DATA_W'($urandom), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_counter.md
# bit_counter

Sequential population-count engine. It is armed by a start pulse, captures an 8-bit word on a load pulse, and serially counts the set bits, one bit per clock. It flags completion with a level `o_done`. The block sits as a small standalone datapath/FSM peripheral and is driven by a controller that sequences start and load as single-cycle pulses.

## Interface
- `DATA_W`, default 8: width of the word to be counted.
- `SUM_W`, default 4: width of the result, equal to clog2(DATA_W+1).
- `i_clk` input 1: system clock. All state changes on the rising edge.
- `i_rst_n` input 1: reset. Asynchronous and active-low.
- `i_start` input 1: arm/restart pulse.
- `i_load` input 1: capture `i_data` while armed.
- `i_data` input DATA_W: word whose 1-bits are counted.
- `o_sum` output SUM_W: running, then final, count of set bits.
- `o_done` output 1: result valid. Level, held until the next start or reset.

## Operation
- FSM states are IDLE, ARMED, COUNT and DONE.
- **Reset** (asserted any time, including mid-count): state goes to IDLE; `o_sum`=0, `o_done`=0, shift register=0, bit counter=0.
- **IDLE**
  - `i_start`=1 → ARMED; clear `o_sum` and `o_done`.
  - `i_load` is ignored.
- **ARMED**
  - `i_load`=1 → capture `i_data` into the shift register, clear the bit counter, go to COUNT.
  - `i_start` re-arms; this has no visible effect.
- **COUNT**, on each edge:
  - `o_sum` += shreg[0].
  - Shift the register right one place and increment the bit counter.
  - After DATA_W bits → DONE, `o_done`=1.
- **DONE**
  - Hold `o_sum` and `o_done`.
  - `i_start`=1 → ARMED, clearing `o_sum` and `o_done`.
  - `i_load` is ignored.
- **Priority:** `i_start` beats `i_load` in every state. If both are high on the same edge, the block re-arms and the load is dropped.
- **Restart:** `i_start` during COUNT aborts the count and returns to ARMED with `o_sum`=0 and `o_done`=0.
- **Input stability:** `i_data` is sampled only on the load edge. Later changes to `i_data` have no effect.
- **Arithmetic:** the sum saturates naturally, since its maximum is DATA_W and SUM_W holds it. No overflow is possible.

## Timing
- Reset values: `o_sum`=0, `o_done`=0.
- Load captured at edge L; bit 0 is added at edge L+1.
- `o_done` rises after edge L+DATA_W (edge L+8 at the default), registered together with the final `o_sum`.
- `o_sum` is monotonically non-decreasing during COUNT and is valid only when `o_done`=1.
- Start-to-clear latency is one edge.
- Start and load pulses of any length are accepted. A held `i_start` keeps the block in ARMED.

## Configuration
- **With `BIT_COUNTER_EARLY_EXIT_EN` defined:** COUNT also terminates when the remaining shift register is zero. `o_done` then rises on the edge after the last remaining 1-bit is consumed, or on the edge after load for `i_data`=0, so latency is 1..DATA_W.
- **Without it:** latency is always exactly DATA_W cycles.
- Result values are identical either way.

## Structure
- Package `bit_counter_pkg`:
  - state enum (IDLE, ARMED, COUNT, DONE);
  - default DATA_W constant;
  - function computing SUM_W.
- Sub-module `bit_counter_datapath`: shift register, bit counter and accumulator, with control strobes from the FSM in the top.

## Test plan
- Reset, then start with `i_data`=0xFF, load after 3 cycles → `o_done`=1 exactly 8 edges after load, `o_sum`=8.
- Start again from DONE with `i_data`=0x38 → `o_sum` and `o_done` clear on the start edge; after load and 8 edges, `o_sum`=3.
- Data 0x03, then 0x0F (each preceded by reset) → `o_sum`=2 and `o_sum`=4 respectively.
- Load pulse in IDLE without a prior start → no state change, `o_done` stays 0. Start and load on the same edge → ARMED, load dropped.
- Reset asserted mid-COUNT with 0xFF loaded → `o_sum`=0 and `o_done`=0 immediately (asynchronous). Start during COUNT → count aborted, ARMED.
- Early exit on, with 0x01 → `o_done` after 1 edge, `o_sum`=1. With 0x00 → `o_done` after 1 edge, `o_sum`=0.
